// File: rtl/pc_seq_pkg.sv
// Shared constants for the program-counter sequencer and its return stack.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pc_seq_pkg;

    localparam int ADDR_W_DEF = 32;

    // Next-PC mode encodings driven by the control unit on PC_select.
    localparam logic [2:0] JREG     = 3'd0;
    localparam logic [2:0] SEQ      = 3'd1;
    localparam logic [2:0] BR_REL   = 3'd2;
    localparam logic [2:0] J_ABS    = 3'd3;
    localparam logic [2:0] CALL_ABS = 3'd4;
    localparam logic [2:0] CALL_REL = 3'd5;
    localparam logic [2:0] RET      = 3'd6;
    localparam logic [2:0] HOLD     = 3'd7;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// Circular LIFO of return addresses; a push while full silently overwrites the oldest entry.
// Latency: push/pop/flush take effect at the next Clock edge; dout is the current top, combinational.
// Backpressure: none; the caller checks full/empty. A pop while empty is ignored.
// Ports: push/pop/flush commands, din pushed value, dout top entry, count/full/empty status.
module return_stack
    import pc_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = ADDR_W_DEF
) (
    input  logic                     Clock,
    input  logic                     Reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] ptr;
    logic [PW-1:0] top_idx;

    // ptr is the next write slot, so the top of stack sits one below it.
    // When full, ptr has wrapped onto the oldest entry, which is exactly
    // the slot a further push should overwrite.
    assign top_idx = ptr - PW'(1);
    assign dout    = mem[top_idx];
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            ptr   <= '0;
            count <= '0;
        end else if (flush) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PW'(1);
            if (!full) begin
                count <= count + (PW+1)'(1);
            end
        end else if (pop && !empty) begin
            ptr   <= top_idx;
            count <= count - (PW+1)'(1);
        end
    end

    // Entry contents need no reset; count governs what is valid.
    always_ff @(posedge Clock) begin
        if (push && !flush) begin
            mem[ptr] <= din;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: picks next fetch address (seq/branch/jump/call/return/boot), keeps a RAS.
// Latency: PC and PC_temp are registered; a new value appears one cycle after the enabling edge.
// Backpressure: PC_enable=0 stalls everything except Clear_flags; Boot_load overrides the stall.
// Ports: Clock/Reset_n; PC_enable, PC_select, Branch_taken, BranchOff, RA, Boot_load, JumpTo,
//        Clear_flags in; PC, PC_temp, RAS_count, sticky RAS_overflow/RAS_underflow out.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int INC       = 1,
    parameter int RAS_DEPTH = 4,
    parameter int BOOT_W    = 7
) (
    input  logic                         Clock,
    input  logic                         Reset_n,
    input  logic                         PC_enable,
    input  logic [2:0]                   PC_select,
    input  logic                         Branch_taken,
    input  logic [ADDR_W-1:0]            BranchOff,
    input  logic [ADDR_W-1:0]            RA,
    input  logic                         Boot_load,
    input  logic [BOOT_W-1:0]            JumpTo,
    input  logic                         Clear_flags,
    output logic [ADDR_W-1:0]            PC,
    output logic [ADDR_W-1:0]            PC_temp,
    output logic [$clog2(RAS_DEPTH):0]   RAS_count,
    output logic                         RAS_overflow,
    output logic                         RAS_underflow
);

    localparam logic [ADDR_W-1:0] INC_V = ADDR_W'(INC);

    logic              step;        // enabled advance not pre-empted by a boot load
    logic [ADDR_W-1:0] pc_seq;
    logic [ADDR_W-1:0] pc_rel;
    logic [ADDR_W-1:0] pc_next;
    logic              want_push;
    logic              want_pop;
    logic              ras_push;
    logic              ras_pop;
    logic [ADDR_W-1:0] ras_dout;
    logic              ras_full;
    logic              ras_empty;
    logic              ovf_set;
    logic              unf_set;

    assign step   = PC_enable && !Boot_load;
    assign pc_seq = PC + INC_V;
    assign pc_rel = PC + BranchOff;   // modulo 2^ADDR_W, two's-complement offset

    always_comb begin
        pc_next   = PC;
        want_push = 1'b0;
        want_pop  = 1'b0;
        case (PC_select)
            JREG:     pc_next = RA;
            SEQ:      pc_next = pc_seq;
            BR_REL:   pc_next = Branch_taken ? pc_rel : pc_seq;
            J_ABS:    pc_next = BranchOff;
            CALL_ABS: begin
                want_push = 1'b1;
                pc_next   = BranchOff;
            end
            CALL_REL: begin
                want_push = 1'b1;
                pc_next   = pc_rel;
            end
            RET: begin
                // An empty stack leaves PC where it is; only the flag records it.
                want_pop = 1'b1;
                if (!ras_empty) begin
                    pc_next = ras_dout;
                end
            end
            default:  pc_next = PC;   // HOLD
        endcase
    end

    assign ras_push = step && want_push;
    assign ras_pop  = step && want_pop;
    assign ovf_set  = ras_push && ras_full;
    assign unf_set  = ras_pop && ras_empty;

    return_stack #(
        .DEPTH (RAS_DEPTH),
        .W     (ADDR_W)
    ) u_ras (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .push    (ras_push),
        .pop     (ras_pop),
        .flush   (Boot_load),
        .din     (pc_seq),
        .dout    (ras_dout),
        .count   (RAS_count),
        .full    (ras_full),
        .empty   (ras_empty)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            PC      <= '0;
            PC_temp <= '0;
        end else if (Boot_load) begin
            PC      <= ADDR_W'(JumpTo);
            PC_temp <= PC;
        end else if (PC_enable) begin
            PC      <= pc_next;
            PC_temp <= PC;
        end
    end

    // Sticky flags: a set in the same cycle beats a clear.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            RAS_overflow  <= 1'b0;
            RAS_underflow <= 1'b0;
        end else begin
            if (ovf_set) begin
                RAS_overflow <= 1'b1;
            end else if (Clear_flags) begin
                RAS_overflow <= 1'b0;
            end
            if (unf_set) begin
                RAS_underflow <= 1'b1;
            end else if (Clear_flags) begin
                RAS_underflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer with default parameters (32-bit PC, depth-4 stack).
// Expected state is queued as each cycle is driven; observed state is queued after the edge.
// Each scenario task drains and compares both queues itself.
module tb_pc_sequencer;
    import pc_seq_pkg::*;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] temp;
        logic [2:0]  cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    logic        Clock;
    logic        Reset_n;
    logic        PC_enable;
    logic [2:0]  PC_select;
    logic        Branch_taken;
    logic [31:0] BranchOff;
    logic [31:0] RA;
    logic        Boot_load;
    logic [6:0]  JumpTo;
    logic        Clear_flags;
    logic [31:0] PC;
    logic [31:0] PC_temp;
    logic [2:0]  RAS_count;
    logic        RAS_overflow;
    logic        RAS_underflow;

    exp_t sb[$];
    exp_t obs[$];
    int   checks = 0;
    int   errors = 0;

    pc_sequencer dut (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .PC_enable     (PC_enable),
        .PC_select     (PC_select),
        .Branch_taken  (Branch_taken),
        .BranchOff     (BranchOff),
        .RA            (RA),
        .Boot_load     (Boot_load),
        .JumpTo        (JumpTo),
        .Clear_flags   (Clear_flags),
        .PC            (PC),
        .PC_temp       (PC_temp),
        .RAS_count     (RAS_count),
        .RAS_overflow  (RAS_overflow),
        .RAS_underflow (RAS_underflow)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] temp,
                                input logic [2:0] cnt, input logic ovf, input logic unf);
        exp_t e;
        e.pc = pc; e.temp = temp; e.cnt = cnt; e.ovf = ovf; e.unf = unf;
        return e;
    endfunction

    // Drive one cycle, queue its expectation, sample the result after the edge.
    task automatic apply(input logic [2:0] sel, input logic en, input logic br,
                         input logic [31:0] off, input logic [31:0] ra, input logic boot,
                         input logic [6:0] jt, input logic clr, input exp_t e);
        PC_select = sel; PC_enable = en; Branch_taken = br; BranchOff = off;
        RA = ra; Boot_load = boot; JumpTo = jt; Clear_flags = clr;
        sb.push_back(e);
        @(posedge Clock);
        #1;
        obs.push_back({PC, PC_temp, RAS_count, RAS_overflow, RAS_underflow});
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; PC_enable = 1'b1; PC_select = SEQ; Branch_taken = 1'b0;
        BranchOff = '0; RA = '0; Boot_load = 1'b0; JumpTo = '0; Clear_flags = 1'b0;
        #12;
        checks++;
        if ({PC, PC_temp, RAS_count, RAS_overflow, RAS_underflow} !== mk(0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset: pc=%h temp=%h cnt=%0d ovf=%b unf=%b, expected all zero",
                     PC, PC_temp, RAS_count, RAS_overflow, RAS_underflow);
        end
        Reset_n = 1'b1;
    endtask

    task automatic test_seq();
        exp_t e, o;
        apply(SEQ, 1, 0, 0, 0, 0, 0, 0, mk(1, 0, 0, 0, 0));
        apply(SEQ, 1, 0, 0, 0, 0, 0, 0, mk(2, 1, 0, 0, 0));
        apply(SEQ, 1, 0, 0, 0, 0, 0, 0, mk(3, 2, 0, 0, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); o = obs.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL seq[%0d]: pc=%h temp=%h cnt=%0d ovf=%b unf=%b, expected pc=%h temp=%h cnt=%0d ovf=%b unf=%b",
                         i, o.pc, o.temp, o.cnt, o.ovf, o.unf, e.pc, e.temp, e.cnt, e.ovf, e.unf);
            end
        end
        // Asynchronous reset between edges.
        #1 Reset_n = 1'b0;
        #2;
        checks++;
        if ({PC, PC_temp, RAS_count} !== {32'd0, 32'd0, 3'd0}) begin
            errors++;
            $display("FAIL async_reset: pc=%h temp=%h cnt=%0d, expected 0 0 0", PC, PC_temp, RAS_count);
        end
        #1 Reset_n = 1'b1;
    endtask

    task automatic test_boot();
        exp_t e, o;
        apply(SEQ, 1, 0, 0, 0, 1, 7'h55, 0, mk(32'h55, 0, 0, 0, 0));
        apply(SEQ, 0, 0, 0, 0, 0, 0, 0, mk(32'h55, 0, 0, 0, 0));
        apply(SEQ, 0, 0, 0, 0, 0, 0, 0, mk(32'h55, 0, 0, 0, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); o = obs.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL boot[%0d]: pc=%h temp=%h cnt=%0d ovf=%b unf=%b, expected pc=%h temp=%h cnt=%0d ovf=%b unf=%b",
                         i, o.pc, o.temp, o.cnt, o.ovf, o.unf, e.pc, e.temp, e.cnt, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_branch();
        exp_t e, o;
        apply(J_ABS,  1, 0, 32'h10,       0, 0, 0, 0, mk(32'h10, 32'h55, 0, 0, 0));
        apply(BR_REL, 1, 1, 32'hFFFFFFFC, 0, 0, 0, 0, mk(32'h0C, 32'h10, 0, 0, 0));
        apply(J_ABS,  1, 0, 32'h10,       0, 0, 0, 0, mk(32'h10, 32'h0C, 0, 0, 0));
        apply(BR_REL, 1, 0, 32'hFFFFFFFC, 0, 0, 0, 0, mk(32'h11, 32'h10, 0, 0, 0));
        apply(J_ABS,  1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, mk(32'hFFFFFFFF, 32'h11, 0, 0, 0));
        apply(SEQ,    1, 0, 0,            0, 0, 0, 0, mk(32'h0, 32'hFFFFFFFF, 0, 0, 0));
        apply(CALL_REL, 1, 0, 32'h30,     0, 0, 0, 0, mk(32'h30, 32'h0, 1, 0, 0));
        apply(RET,    1, 0, 0,            0, 0, 0, 0, mk(32'h1, 32'h30, 0, 0, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); o = obs.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL branch[%0d]: pc=%h temp=%h cnt=%0d ovf=%b unf=%b, expected pc=%h temp=%h cnt=%0d ovf=%b unf=%b",
                         i, o.pc, o.temp, o.cnt, o.ovf, o.unf, e.pc, e.temp, e.cnt, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_call_ret();
        exp_t e, o;
        apply(J_ABS,    1, 0, 32'h20,  0, 0, 0, 0, mk(32'h20,  32'h1,   0, 0, 0));
        apply(CALL_ABS, 1, 0, 32'h100, 0, 0, 0, 0, mk(32'h100, 32'h20,  1, 0, 0));
        apply(RET,      1, 0, 0,       0, 0, 0, 0, mk(32'h21,  32'h100, 0, 0, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); o = obs.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL call_ret[%0d]: pc=%h temp=%h cnt=%0d ovf=%b unf=%b, expected pc=%h temp=%h cnt=%0d ovf=%b unf=%b",
                         i, o.pc, o.temp, o.cnt, o.ovf, o.unf, e.pc, e.temp, e.cnt, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_overflow();
        exp_t e, o;
        apply(J_ABS, 1, 0, 32'h1, 0, 0, 0, 0, mk(1, 32'h21, 0, 0, 0));
        // Chained calls 1->2->...->6; the fifth overwrites the oldest return address.
        for (int k = 1; k <= 5; k++) begin
            apply(CALL_ABS, 1, 0, 32'(k + 1), 0, 0, 0, 0,
                  mk(32'(k + 1), 32'(k), (k < 4) ? 3'(k) : 3'd4, (k == 5), 0));
        end
        apply(RET, 1, 0, 0, 0, 0, 0, 0, mk(6, 6, 3, 1, 0));
        apply(RET, 1, 0, 0, 0, 0, 0, 0, mk(5, 6, 2, 1, 0));
        apply(RET, 1, 0, 0, 0, 0, 0, 0, mk(4, 5, 1, 1, 0));
        apply(RET, 1, 0, 0, 0, 0, 0, 0, mk(3, 4, 0, 1, 0));
        apply(RET, 1, 0, 0, 0, 0, 0, 0, mk(3, 3, 0, 1, 1));
        apply(SEQ, 0, 0, 0, 0, 0, 0, 1, mk(3, 3, 0, 0, 0));
        // Underflow in the same cycle as a clear: the set wins.
        apply(RET, 1, 0, 0, 0, 0, 0, 1, mk(3, 3, 0, 0, 1));
        apply(SEQ, 0, 0, 0, 0, 0, 0, 1, mk(3, 3, 0, 0, 0));
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); o = obs.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL overflow[%0d]: pc=%h temp=%h cnt=%0d ovf=%b unf=%b, expected pc=%h temp=%h cnt=%0d ovf=%b unf=%b",
                         i, o.pc, o.temp, o.cnt, o.ovf, o.unf, e.pc, e.temp, e.cnt, e.ovf, e.unf);
            end
        end
    endtask

    task automatic test_misc();
        exp_t e, o;
        apply(JREG,     1, 0, 0,       32'hDEAD, 0, 0,     0, mk(32'hDEAD, 3,        0, 0, 0));
        apply(HOLD,     1, 0, 0,       0,        0, 0,     0, mk(32'hDEAD, 32'hDEAD, 0, 0, 0));
        apply(CALL_ABS, 1, 0, 32'h40,  0,        0, 0,     0, mk(32'h40,   32'hDEAD, 1, 0, 0));
        apply(CALL_ABS, 1, 0, 32'h999, 0,        1, 7'h7F, 0, mk(32'h7F,   32'h40,   0, 0, 0));
        apply(RET,      1, 0, 0,       0,        0, 0,     0, mk(32'h7F,   32'h7F,   0, 0, 1));
        for (int i = 0; sb.size() > 0; i++) begin
            e = sb.pop_front(); o = obs.pop_front(); checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL misc[%0d]: pc=%h temp=%h cnt=%0d ovf=%b unf=%b, expected pc=%h temp=%h cnt=%0d ovf=%b unf=%b",
                         i, o.pc, o.temp, o.cnt, o.ovf, o.unf, e.pc, e.temp, e.cnt, e.ovf, e.unf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_boot();
        test_branch();
        test_call_ret();
        test_overflow();
        test_misc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
